rtc_bus_reader: RTL and testbench

//  Bus-cycle engine directly downstream of the RTC main state machine. Takes the
//  2-bit mode code that machine drives on out[1:0] (00 idle, 01 date, 10 time,
//  11 timer) and runs a 3-register read burst on the RTC chip's multiplexed

---
 rtl/rtc_bus_reader_if.sv | 37 +++
 rtl/rtc_bus_reader.sv | 232 +++++++++++++++++++++++
 tb/tb_rtc_bus_reader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_reader_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_reader_if
//   Groups the request/result handshake and the RTC chip's multiplexed
//   address/data bus for rtc_bus_reader.
//   master : the bus-cycle engine (consumes mode/req/ad_in, drives the rest)
//   slave  : the environment (main FSM, display logic, RTC chip pads)
//   Signals:
//     mode[1:0]      burst select from the main FSM (00 = no access)
//     req            level request
//     busy, done     burst in progress / one-cycle completion pulse
//     data_out[23:0] {reg2, reg1, reg0} of the last completed burst
//     cs_n, rd_n, wr_n, a_d, ad_oe, ad_out[7:0], ad_in[7:0]  chip bus
// ---------------------------------------------------------------------------
interface rtc_bus_reader_if;
    logic [1:0]  mode;
    logic        req;
    logic        busy;
    logic        done;
    logic [23:0] data_out;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic        a_d;
    logic        ad_oe;
    logic [7:0]  ad_out;
    logic [7:0]  ad_in;

    modport master (
        input  mode, req, ad_in,
        output busy, done, data_out, cs_n, rd_n, wr_n, a_d, ad_oe, ad_out
    );

    modport slave (
        output mode, req, ad_in,
        input  busy, done, data_out, cs_n, rd_n, wr_n, a_d, ad_oe, ad_out
    );
endinterface

// File: rtl/rtc_bus_reader.sv
// ---------------------------------------------------------------------------
// rtc_bus_reader
//   Bus-cycle engine behind the RTC main state machine. On a request with a
//   non-zero mode it reads three consecutive RTC registers starting at the
//   mode's base address, over the chip's multiplexed address/data bus, and
//   returns {reg2, reg1, reg0} with a one-cycle done pulse.
//
//   Per register: ADDR (PHASE_CYC clocks, wr_n strobe latches the address),
//   HOLD (1 clock), DATA (PHASE_CYC clocks, rd_n strobe, ad_in captured on the
//   last one), GAP (1 clock). After the third register: DONE (1 clock).
//
//   Ports:
//     clk      system clock, rising edge
//     swreset  asynchronous active-low reset
//     bus      rtc_bus_reader_if.master (handshake, result and chip bus)
// ---------------------------------------------------------------------------
module rtc_bus_reader #(
    parameter int unsigned PHASE_CYC  = 4,      // 1..255
    parameter logic [7:0]  ADDR_DATE  = 8'h24,
    parameter logic [7:0]  ADDR_TIME  = 8'h21,
    parameter logic [7:0]  ADDR_TIMER = 8'h41
) (
    input  logic              clk,
    input  logic              swreset,
    rtc_bus_reader_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_HOLD,
        S_DATA,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  mode_q, mode_d;
    logic [23:0] shadow_q, shadow_d;
    logic [23:0] data_q, data_d;

    // Registered bus/handshake outputs: decoded from the next state so every
    // strobe comes straight off a flop and is glitch-free.
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        a_d_q, a_d_d;
    logic        ad_oe_q, ad_oe_d;
    logic [7:0]  ad_out_q, ad_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        phase_end;

    assign phase_end = (cnt_q == PHASE_LAST);

    function automatic logic [7:0] base_of(input logic [1:0] m);
        logic [7:0] b;
        case (m)
            2'b01:   b = ADDR_DATE;
            2'b10:   b = ADDR_TIME;
            default: b = ADDR_TIMER;   // 2'b11; 2'b00 never starts a burst
        endcase
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge swreset) begin
        if (!swreset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            mode_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        shadow_d = shadow_q;
        data_d   = data_q;

        unique case (state_q)
            S_IDLE: begin
                // mode is latched here; later changes on the input are ignored
                if (bus.req && (bus.mode != 2'b00)) begin
                    mode_d  = bus.mode;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (phase_end) begin
                    case (idx_q)
                        2'd0:    shadow_d[7:0]   = bus.ad_in;
                        2'd1:    shadow_d[15:8]  = bus.ad_in;
                        default: shadow_d[23:16] = bus.ad_in;
                    endcase
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (idx_q == 2'd2) begin
                    // whole-word update: data_out never shows a partial burst
                    data_d  = shadow_q;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (from next state) and output registers
    // -----------------------------------------------------------------------
    always_comb begin
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;       // address holds outside ADDR
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_d)
            S_ADDR: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = base_of(mode_d) + {6'b0, idx_d};
                busy_d   = 1'b1;
            end
            S_HOLD: begin
                // keep driving the address while wr_n rises so it latches cleanly
                ad_oe_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_DATA: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
                busy_d = 1'b1;
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge swreset) begin
        if (!swreset) begin
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            a_d_q    <= a_d_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.cs_n     = cs_n_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.a_d      = a_d_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.ad_out   = ad_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = data_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_reader
//   Two instances: dut4 (PHASE_CYC=4) for single bursts, reset and idle
//   behaviour; dut1 (PHASE_CYC=1) for continuous back-to-back refresh.
//   An RTC register file (mem) answers reads at the address latched by wr_n.
//   Expected results come from the register map and burst-length formula.
// ---------------------------------------------------------------------------
module tb_rtc_bus_reader;
    localparam int P4     = 4;
    localparam int P1     = 1;
    localparam int BURST4 = 3 * (2 * P4 + 2);
    localparam int BURST1 = 3 * (2 * P1 + 2);

    logic clk     = 1'b0;
    logic swreset = 1'b1;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    logic [7:0] mem [256];

    rtc_bus_reader_if if4();
    rtc_bus_reader_if if1();

    rtc_bus_reader #(.PHASE_CYC(P4)) dut4 (.clk(clk), .swreset(swreset), .bus(if4.master));
    rtc_bus_reader #(.PHASE_CYC(P1)) dut1 (.clk(clk), .swreset(swreset), .bus(if1.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- observation / bus model, dut4 ----------------
    logic [7:0]  addr4 [$];
    int          busy4 [$];
    logic [23:0] data4 [$];
    int          donec4 [$];
    int          run4 = 0, cslow4 = 0, viol4 = 0;
    logic        pwr4 = 1'b1;
    logic [7:0]  lat4 = 8'h00;

    always @(negedge clk) begin
        if (!swreset) begin
            run4 = 0;
            pwr4 = 1'b1;
        end else begin
            if (if4.busy) run4++;
            else if (run4 > 0) begin busy4.push_back(run4); run4 = 0; end
            if (!if4.wr_n && pwr4) addr4.push_back(if4.ad_out);
            pwr4 = if4.wr_n;
            if (if4.done) begin data4.push_back(if4.data_out); donec4.push_back(cyc); end
            if (!if4.cs_n) cslow4++;
            if (!if4.rd_n && !if4.wr_n) viol4++;
        end
        if (!if4.wr_n) lat4 = if4.ad_out;
        if4.ad_in = !if4.rd_n ? mem[lat4] : 8'($urandom);
    end

    // ---------------- observation / bus model, dut1 ----------------
    int          busy1 [$];
    int          gaps1 [$];
    logic [23:0] data1 [$];
    int          run1 = 0, gap1 = 0, viol1 = 0;
    bit          seen1 = 1'b0;
    logic [7:0]  lat1 = 8'h00;

    always @(negedge clk) begin
        if (!swreset) begin
            run1 = 0;
        end else begin
            if (if1.busy) begin
                if (run1 == 0 && seen1) gaps1.push_back(gap1);
                run1++;
            end else begin
                if (run1 > 0) begin busy1.push_back(run1); run1 = 0; seen1 = 1'b1; gap1 = 0; end
                gap1++;
            end
            if (if1.done) data1.push_back(if1.data_out);
            if (!if1.rd_n && !if1.wr_n) viol1++;
        end
        if (!if1.wr_n) lat1 = if1.ad_out;
        if1.ad_in = !if1.rd_n ? mem[lat1] : 8'($urandom);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_base(input logic [1:0] m);
        case (m)
            2'b01:   return 8'h24;
            2'b10:   return 8'h21;
            default: return 8'h41;
        endcase
    endfunction

    function automatic logic [23:0] exp_data(input logic [1:0] m);
        logic [7:0] a0, a1, a2;
        a0 = exp_base(m);
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        return {mem[a2], mem[a1], mem[a0]};
    endfunction

    task automatic clear4();
        addr4.delete(); busy4.delete(); data4.delete(); donec4.delete();
        cslow4 = 0;
    endtask

    // One dut4 burst: 1-cycle req pulse, optional noise on mode/req while busy.
    task automatic run_burst(input logic [1:0] m, input bit noise);
        int          samp;
        logic [23:0] expd;
        logic [7:0]  b;
        clear4();
        b    = exp_base(m);
        expd = exp_data(m);
        if4.mode = m;
        if4.req  = 1'b1;
        samp     = cyc + 1;           // the next rising edge samples req
        tick();
        if4.req = 1'b0;
        if (noise) begin
            repeat (20) begin
                if4.mode = 2'($urandom);
                if4.req  = 1'($urandom);
                tick();
            end
            if4.req  = 1'b0;
            if4.mode = 2'($urandom);
        end
        for (int t = 0; t < 4 * BURST4 && data4.size() == 0; t++) tick();
        chk("done_seen", data4.size(), 1);
        // done is visible after the BURST4-th edge following the sampling edge
        if (donec4.size() > 0) chk("done_latency", donec4[0] - samp, BURST4);
        chk("busy_runs", busy4.size(), 1);
        if (busy4.size() > 0) chk("busy_len", busy4[0], BURST4);
        chk("addr_count", addr4.size(), 3);
        for (int j = 0; j < 3 && j < addr4.size(); j++)
            chk("addr", addr4[j], b + 8'(j));
        if (data4.size() > 0) chk("data_out", data4[0], expd);
        repeat (3) tick();
        chk("single_done", data4.size(), 1);
        chk("data_hold", if4.data_out, expd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  m;
        logic [23:0] expd;
        bit          found;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        if4.mode = 2'b00; if4.req = 1'b0;
        if1.mode = 2'b00; if1.req = 1'b0;
        #2 swreset = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_cs_n", if4.cs_n, 1);
        chk("rst_rd_n", if4.rd_n, 1);
        chk("rst_wr_n", if4.wr_n, 1);
        chk("rst_a_d", if4.a_d, 1);
        chk("rst_ad_oe", if4.ad_oe, 0);
        chk("rst_ad_out", if4.ad_out, 0);
        chk("rst_busy", if4.busy, 0);
        chk("rst_done", if4.done, 0);
        chk("rst_data", if4.data_out, 0);
        swreset = 1'b1;
        repeat (2) tick();

        // time burst with known register contents
        mem[8'h21] = 8'h59; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
        run_burst(2'b10, 1'b0);
        chk("time_value", if4.data_out, 24'h123059);

        // randomized bursts over all modes, mode/req noise while busy
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
            m = 2'(i % 3 + 1);
            run_burst(m, (i % 2) == 1);
            repeat ($urandom_range(1, 4)) tick();
        end

        // mode 00 with req held: no access at all
        clear4();
        if4.mode = 2'b00;
        if4.req  = 1'b1;
        repeat (50) tick();
        if4.req = 1'b0;
        chk("m0_busy_runs", busy4.size(), 0);
        chk("m0_busy", if4.busy, 0);
        chk("m0_done", data4.size(), 0);
        chk("m0_cs_low", cslow4, 0);

        // reset during DATA of the second register
        clear4();
        m = 2'($urandom_range(1, 3));
        if4.mode = m;
        if4.req  = 1'b1;
        tick();
        if4.req = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 4 * BURST4; t++) begin
            if (addr4.size() == 2 && !if4.rd_n) begin found = 1'b1; break; end
            tick();
        end
        chk("rst_reach_data2", found, 1);
        swreset = 1'b0;
        #1;
        chk("midrst_cs_n", if4.cs_n, 1);
        chk("midrst_rd_n", if4.rd_n, 1);
        chk("midrst_ad_oe", if4.ad_oe, 0);
        chk("midrst_busy", if4.busy, 0);
        chk("midrst_data", if4.data_out, 0);
        tick();
        swreset = 1'b1;
        repeat (5) tick();
        chk("postrst_busy", if4.busy, 0);
        chk("postrst_cs_n", if4.cs_n, 1);
        chk("postrst_no_done", data4.size(), 0);
        run_burst(2'($urandom_range(1, 3)), 1'b0);
        chk("rd_wr_overlap4", viol4, 0);

        // continuous refresh on dut1
        m    = 2'($urandom_range(1, 3));
        expd = exp_data(m);
        if1.mode = m;
        if1.req  = 1'b1;
        for (int t = 0; t < 400 && busy1.size() < 5; t++) tick();
        if1.req = 1'b0;
        repeat (3 * BURST1) tick();
        chk("b2b_bursts", busy1.size() >= 5, 1);
        chk("b2b_dones", data1.size(), busy1.size());
        foreach (busy1[i]) chk("b2b_busy_len", busy1[i], BURST1);
        // between bursts: DONE cycle plus one IDLE cycle
        chk("b2b_gap_cnt", gaps1.size(), busy1.size() - 1);
        foreach (gaps1[i]) chk("b2b_gap", gaps1[i], 2);
        foreach (data1[i]) chk("b2b_data", data1[i], expd);
        chk("rd_wr_overlap1", viol1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
